exec_unit: RTL and testbench
============================

# exec_unit

Execute stage of the 16-bit CPU, directly downstream of the register file. It consumes the two read operands and an operation code, computes the result, and drives the register file write port (`we`, `addrR`, `dataR`) for writeback. Logic and add/shift ops complete in one cycle. An optional iterative shift-add multiplier takes 16 cycles and stalls issue through a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; only 16 is supported.
- `MUL_CYCLES`, 16: multiplier iterations; must equal `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  an operation is presented this cycle.
- `ready_out`  out  1  the unit accepts an operation this cycle; high only in IDLE.
- `op`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `rd`  in  3  destination register index.
- `opA`  in  16  operand A (register file `dataA`).
- `opB`  in  16  operand B (register file `dataB`).
- `we`  out  1  register file write enable; one-cycle pulse per completed op.
- `addrR`  out  3  writeback register index.
- `dataR`  out  16  writeback data.
- `zero`  out  1  the last written result was 0x0000.
- `carry`  out  1  carry, borrow, shift-out or overflow of the last written result.
- `illegal`  out  1  one-cycle pulse when an unsupported op is accepted.

## Operation
- Accept: `valid_in & ready_out` on a rising edge. On accept, `op`, `rd`, `opA` and `opB` are latched. Later changes to the register file do not affect the op in flight.
- States:
  - IDLE: `ready_out` = 1. Accepting a non-MUL op stays in IDLE. Accepting MUL goes to MUL.
  - MUL: `ready_out` = 0. Runs 16 shift-add iterations into a 32-bit accumulator, then returns to IDLE.
- Arithmetic:
  - ADD: `carry` = bit 16 of the 17-bit sum.
  - SUB (A−B): `carry` = borrow, i.e. 1 when A < B unsigned.
  - AND, OR, XOR: `carry` = 0.
  - SHL and SHR: logical shift of A by `opB[3:0]`; `opB[15:4]` is ignored. `carry` = last bit shifted out; a shift by 0 gives `carry` = 0.
  - MUL: `dataR` = product[15:0]; `carry` = (product[31:16] != 0).
- `zero` and `carry` update only when `we` pulses and hold otherwise.
- `addrR` and `dataR` are registered. They hold their last value when `we` = 0.
- `rd` = 0 is an ordinary register with no special handling.

## Timing
- Reset values: `we` 0, `addrR` 0, `dataR` 0x0000, `zero` 0, `carry` 0, `illegal` 0. State is IDLE, so `ready_out` = 1.
- Single-cycle ops: accepted at edge N, `we` = 1 during the cycle after edge N, for exactly one cycle. Back-to-back accepts produce consecutive `we` pulses, one per cycle.
- MUL accepted at edge N:
  - `ready_out` falls after edge N.
  - Iterations run on edges N+1 through N+16.
  - `we` is high for the cycle after edge N+16, so latency is 17 edges.
  - `ready_out` is back to 1 in that same cycle, so a new op can be accepted at edge N+17.
- `valid_in` while `ready_out` = 0 is ignored. The producer must hold its op until it is accepted.
- Reset asserted mid-MUL: the multiply is aborted, no `we` is issued, and all outputs return to reset values immediately.

## Configuration
- `EXEC_MUL_EN` defined:
  - The MUL state and multiplier datapath are compiled in.
  - `illegal` is tied to 0.
- `EXEC_MUL_EN` undefined:
  - No MUL state and no multiplier logic.
  - op 111 is accepted as a single-cycle op. The cycle after acceptance, `illegal` pulses and `we` stays 0.
  - `dataR`, `zero` and `carry` are unchanged.
  - `ready_out` stays 1.

## Test plan
- Reset, then ADD `opA`=0xFFFF, `opB`=0x0001, `rd`=3: one cycle later `we`=1, `addrR`=3, `dataR`=0x0000, `zero`=1, `carry`=1.
- SUB 0x0003−0x0005, then SHL 0x8001 by `opB`=0x0011 (shift 1), issued back to back: consecutive `we` pulses. First pulse gives `dataR`=0xFFFE, `carry`=1. Second gives `dataR`=0x0002, `carry`=1.
- With `EXEC_MUL_EN`, MUL 0x012C×0x0007, `rd`=5:
  - `ready_out` is 0 for 16 cycles.
  - `we` pulses 17 cycles after accept with `dataR`=0x0834, `carry`=0, `zero`=0.
  - `valid_in` held during the stall is accepted on the first cycle `ready_out`=1.
- With `EXEC_MUL_EN`, MUL 0x0100×0x0100: `dataR`=0x0000, `zero`=1, `carry`=1.
- MUL accepted, `reset_n` pulsed low 8 cycles later: no `we` pulse ever occurs, all outputs return to reset values, and `ready_out`=1.
- Without `EXEC_MUL_EN`, op 111: `illegal` pulses for one cycle, `we` stays 0, and the following ADD completes normally.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/shift ops with registered writeback to the register file.
// Optional iterative shift-add multiplier is compiled in when EXEC_MUL_EN is defined.
module exec_unit #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       op,
  input  logic [2:0]       rd,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             we,
  output logic [2:0]       addrR,
  output logic [WIDTH-1:0] dataR,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  if (WIDTH != 16 || MUL_CYCLES != WIDTH) begin : g_bad_cfg
    $error("exec_unit supports only WIDTH == MUL_CYCLES == 16");
  end

  // Returns {last bit shifted out, shifted value}; a zero shift reports no carry.
  function automatic logic [WIDTH:0] shl_f(input logic [WIDTH-1:0] a, input logic [3:0] s);
    return {1'b0, a} << s;
  endfunction

  function automatic logic [WIDTH:0] shr_f(input logic [WIDTH-1:0] a, input logic [3:0] s);
    logic [WIDTH:0] t;
    t = {a, 1'b0} >> s;
    return {t[0], t[WIDTH:1]};
  endfunction

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_r;
  logic [WIDTH:0]   shr_r;

  assign accept = valid_in & ready_out;
  assign sum    = {1'b0, opA} + {1'b0, opB};
  assign diff   = {1'b0, opA} - {1'b0, opB};
  assign shl_r  = shl_f(opA, opB[3:0]);
  assign shr_r  = shr_f(opA, opB[3:0]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];   alu_c = sum[WIDTH];   end
      OP_SUB: begin alu_res = diff[WIDTH-1:0];  alu_c = diff[WIDTH];  end
      OP_AND: alu_res = opA & opB;
      OP_OR:  alu_res = opA | opB;
      OP_XOR: alu_res = opA ^ opB;
      OP_SHL: begin alu_res = shl_r[WIDTH-1:0]; alu_c = shl_r[WIDTH]; end
      OP_SHR: begin alu_res = shr_r[WIDTH-1:0]; alu_c = shr_r[WIDTH]; end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state;

  logic [CNT_W-1:0]   cnt_p1;
  logic [2:0]         rd_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_nxt;

  assign ready_out = (state == IDLE);
  assign illegal   = 1'b0;
  assign acc_nxt   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt_p1 <= '0;
      we     <= 1'b0;
      addrR  <= '0;
      dataR  <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state  <= MUL;
              cnt_p1 <= '0;
            end else begin
              we    <= 1'b1;
              addrR <= rd;
              dataR <= alu_res;
              zero  <= (alu_res == '0);
              carry <= alu_c;
            end
          end
        end
        MUL: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          // Final iteration: the accumulator's next value is the full product.
          if (cnt_p1 == CNT_W'(MUL_CYCLES - 1)) begin
            state <= IDLE;
            we    <= 1'b1;
            addrR <= rd_p1;
            dataR <= acc_nxt[WIDTH-1:0];
            zero  <= (acc_nxt[WIDTH-1:0] == '0);
            carry <= |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Multiplier datapath: operands latched on accept, one shift-add per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept && op == OP_MUL) begin
      rd_p1     <= rd;
      mcand_p1  <= {{WIDTH{1'b0}}, opA};
      mplier_p1 <= opB;
      acc_p1    <= '0;
    end else if (state == MUL) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
`else
  assign ready_out = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we      <= 1'b0;
      illegal <= 1'b0;
      addrR   <= '0;
      dataR   <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      we      <= 1'b0;
      illegal <= 1'b0;
      if (accept) begin
        // Without the multiplier, MUL is flagged and leaves the flags untouched.
        if (op == OP_MUL) begin
          illegal <= 1'b1;
        end else begin
          we    <= 1'b1;
          addrR <= rd;
          dataR <= alu_res;
          zero  <= (alu_res == '0);
          carry <= alu_c;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; MUL scenarios run only when EXEC_MUL_EN is defined.
module tb_exec_unit;
  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  op;
  logic [2:0]  rd;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        we;
  logic [2:0]  addrR;
  logic [15:0] dataR;
  logic        zero;
  logic        carry;
  logic        illegal;

  int vectors;
  int miscompares;

  exec_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .rd(rd), .opA(opA), .opB(opB),
    .we(we), .addrR(addrR), .dataR(dataR), .zero(zero), .carry(carry), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for one edge, then scramble operands to prove they were latched.
  task automatic apply(input logic [2:0] o, input logic [2:0] r, input logic [15:0] a, input logic [15:0] b);
    valid_in = 1'b1; op = o; rd = r; opA = a; opB = b;
    @(posedge clk); #1;
    valid_in = 1'b0; opA = 16'hDEAD; opB = 16'hBEEF;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; valid_in = 1'b0; op = '0; rd = '0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry, illegal, ready_out} !== {1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got we=%b addrR=%0d dataR=%h z=%b c=%b ill=%b rdy=%b, want 0 0 0000 0 0 0 1",
               we, addrR, dataR, zero, carry, illegal, ready_out);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    apply(3'b000, 3'd3, 16'hFFFF, 16'h0001);
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd3, 16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add_wrap: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 3 0000 1 1", we, addrR, dataR, zero, carry);
    end
    @(posedge clk); #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b0, 3'd3, 16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add_pulse_end: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 0 3 0000 1 1", we, addrR, dataR, zero, carry);
    end
    apply(3'b000, 3'd0, 16'h1234, 16'h0101);
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd0, 16'h1335, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_rd0: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 0 1335 0 0", we, addrR, dataR, zero, carry);
    end
  endtask

  task automatic test_back_to_back;
    apply(3'b001, 3'd1, 16'h0003, 16'h0005);
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd1, 16'hFFFE, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_sub: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 1 fffe 0 1", we, addrR, dataR, zero, carry);
    end
    apply(3'b101, 3'd2, 16'h8001, 16'h0011);
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd2, 16'h0002, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_shl: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 2 0002 0 1", we, addrR, dataR, zero, carry);
    end
    @(posedge clk); #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b0, 3'd2, 16'h0002, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_hold: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 0 2 0002 0 1", we, addrR, dataR, zero, carry);
    end
    apply(3'b001, 3'd6, 16'h0005, 16'h0005);
    vectors++;
    if ({we, dataR, zero, carry} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL sub_equal: got we=%b dataR=%h z=%b c=%b, want 1 0000 1 0", we, dataR, zero, carry);
    end
  endtask

  task automatic test_logic;
    logic [2:0]  ops [3] = '{3'b010, 3'b011, 3'b100};
    logic [15:0] as  [3] = '{16'hF0F0, 16'hF0F0, 16'hAAAA};
    logic [15:0] bs  [3] = '{16'h0FF0, 16'h0F0F, 16'hAAAA};
    logic [15:0] exp [3] = '{16'h00F0, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      apply(3'b000, 3'd7, 16'h8000, 16'h8000);  // leaves carry set beforehand
      apply(ops[i], 3'd4, as[i], bs[i]);
      vectors++;
      if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd4, exp[i], exp[i] == 16'h0000, 1'b0}) begin
        miscompares++;
        $display("FAIL logic_op%0d: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 4 %h %b 0",
                 i, we, addrR, dataR, zero, carry, exp[i], exp[i] == 16'h0000);
      end
    end
  endtask

  task automatic test_shift;
    logic [2:0]  ops [5] = '{3'b110, 3'b101, 3'b110, 3'b101, 3'b110};
    logic [15:0] as  [5] = '{16'h0003, 16'h0001, 16'h8000, 16'hFFFF, 16'h0001};
    logic [15:0] bs  [5] = '{16'hFFF1, 16'h0000, 16'h000F, 16'h000F, 16'h0001};
    logic [15:0] exp [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0000};
    logic        expc[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], 3'd5, as[i], bs[i]);
      vectors++;
      if ({we, dataR, zero, carry} !== {1'b1, exp[i], exp[i] == 16'h0000, expc[i]}) begin
        miscompares++;
        $display("FAIL shift%0d: got we=%b dataR=%h z=%b c=%b, want 1 %h %b %b",
                 i, we, dataR, zero, carry, exp[i], exp[i] == 16'h0000, expc[i]);
      end
    end
  endtask

  task automatic test_idle_hold;
    apply(3'b011, 3'd6, 16'h0F00, 16'h00F0);
    opA = 16'h1111; opB = 16'h2222; op = 3'b000; rd = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry, illegal} !== {1'b0, 3'd6, 16'h0FF0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold: got we=%b addrR=%0d dataR=%h z=%b c=%b ill=%b, want 0 6 0ff0 0 0 0",
               we, addrR, dataR, zero, carry, illegal);
    end
  endtask

`ifndef EXEC_MUL_EN
  task automatic test_illegal;
    apply(3'b000, 3'd2, 16'hFFFF, 16'h0001);  // zero=1, carry=1, dataR=0
    apply(3'b111, 3'd4, 16'h0005, 16'h0006);
    vectors++;
    if ({illegal, we, addrR, dataR, zero, carry, ready_out} !== {1'b1, 1'b0, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_pulse: got ill=%b we=%b addrR=%0d dataR=%h z=%b c=%b rdy=%b, want 1 0 2 0000 1 1 1",
               illegal, we, addrR, dataR, zero, carry, ready_out);
    end
    apply(3'b000, 3'd4, 16'h0002, 16'h0003);
    vectors++;
    if ({illegal, we, addrR, dataR, zero, carry} !== {1'b0, 1'b1, 3'd4, 16'h0005, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL illegal_then_add: got ill=%b we=%b addrR=%0d dataR=%h z=%b c=%b, want 0 1 4 0005 0 0",
               illegal, we, addrR, dataR, zero, carry);
    end
  endtask
`else
  task automatic test_mul;
    int low_cycles;
    int we_early;
    low_cycles = 0;
    we_early = 0;
    valid_in = 1'b1; op = 3'b111; rd = 3'd5; opA = 16'h012C; opB = 16'h0007;
    @(posedge clk); #1;
    // Producer now presents an ADD held through the stall.
    op = 3'b000; rd = 3'd1; opA = 16'h0010; opB = 16'h0020;
    for (int i = 0; i < 16; i++) begin
      if (ready_out === 1'b0) low_cycles++;
      if (we !== 1'b0) we_early++;
      @(posedge clk); #1;
    end
    vectors++;
    if (low_cycles !== 16 || we_early !== 0) begin
      miscompares++;
      $display("FAIL mul_stall: got ready_low=%0d early_we=%0d, want 16 0", low_cycles, we_early);
    end
    vectors++;
    if ({we, addrR, dataR, zero, carry, ready_out} !== {1'b1, 3'd5, 16'h0834, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mul_result: got we=%b addrR=%0d dataR=%h z=%b c=%b rdy=%b, want 1 5 0834 0 0 1",
               we, addrR, dataR, zero, carry, ready_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    vectors++;
    if ({we, addrR, dataR, ready_out} !== {1'b1, 3'd1, 16'h0030, 1'b1}) begin
      miscompares++;
      $display("FAIL mul_held_accept: got we=%b addrR=%0d dataR=%h rdy=%b, want 1 1 0030 1", we, addrR, dataR, ready_out);
    end

    apply(3'b111, 3'd2, 16'h0100, 16'h0100);
    repeat (16) @(posedge clk);
    #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry} !== {1'b1, 3'd2, 16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL mul_overflow: got we=%b addrR=%0d dataR=%h z=%b c=%b, want 1 2 0000 1 1", we, addrR, dataR, zero, carry);
    end
  endtask

  task automatic test_mul_abort;
    int we_seen;
    we_seen = 0;
    apply(3'b000, 3'd3, 16'h1000, 16'h0234);
    apply(3'b111, 3'd6, 16'h00FF, 16'h00FF);
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({we, addrR, dataR, zero, carry, illegal, ready_out} !== {1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mul_abort_reset: got we=%b addrR=%0d dataR=%h z=%b c=%b ill=%b rdy=%b, want 0 0 0000 0 0 0 1",
               we, addrR, dataR, zero, carry, illegal, ready_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (we !== 1'b0) we_seen++;
    end
    vectors++;
    if (we_seen !== 0 || ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_abort_no_we: got we_pulses=%0d rdy=%b, want 0 1", we_seen, ready_out);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_logic();
    test_shift();
    test_idle_hold();
`ifndef EXEC_MUL_EN
    test_illegal();
`else
    test_mul();
    test_mul_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
